// File: rtl/encoder4_2_seq_pkg.sv
// Shared types and helpers for the sequential 4-to-2 request encoder.
package enc_pkg;
  localparam int ENC_N = 4;
  localparam int ENC_W = $clog2(ENC_N);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  function automatic logic [ENC_N-1:0] onehot(input logic [ENC_W-1:0] i);
    onehot = ENC_N'(1) << i;
  endfunction
endpackage

// File: rtl/encoder4_2_seq_if.sv
// Request/grant bundle between request sources, the encoder and its consumer.
interface encoder4_2_seq_if;
  import enc_pkg::*;
  logic             en;
  logic [ENC_N-1:0] req;
  logic             ready;
  logic             valid;
  logic [ENC_W-1:0] idx;
  logic [ENC_N-1:0] pending;
  logic             ovf;

  modport master (output en, req, ready, input valid, idx, pending, ovf);
  modport slave  (input en, req, ready, output valid, idx, pending, ovf);
endinterface

// File: rtl/encoder4_2_seq_prio_enc4.sv
// Combinational priority encoder: index of the highest set bit plus an 'any' flag.
module prio_enc4
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0] i_vec,
  output logic [ENC_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    // Ascending scan: the last set bit seen is the highest one.
    for (int i = 0; i < ENC_N; i++)
      if (i_vec[i]) o_idx = ENC_W'(i);
  end
endmodule

// File: rtl/encoder4_2_seq.sv
// Sequential 4-to-2 request encoder: captures requests into a pending set and
// offers the highest pending index on a valid/ready handshake.
module encoder4_2_seq
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  encoder4_2_seq_if.slave   bus
);
  state_t           r_state;
  logic             r_valid;
  logic [ENC_W-1:0] r_idx;
  logic [ENC_N-1:0] r_pending;
  logic             r_ovf;

  logic [ENC_N-1:0] w_served, w_cap, w_pnext;
  logic [ENC_W-1:0] w_pidx;
  logic             w_any;

  always_comb begin
    w_served = (r_valid && bus.ready) ? onehot(r_idx) : '0;
    w_cap    = bus.en ? bus.req : '0;
    w_pnext  = (r_pending & ~w_served) | w_cap;
  end

  prio_enc4 u_prio (.i_vec(w_pnext), .o_idx(w_pidx), .o_any(w_any));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= w_pnext;
      // A bit served and re-requested on the same edge is not an overflow.
      r_ovf     <= |(w_cap & r_pending & ~w_served);
      case (r_state)
        ST_IDLE:
          if (w_any) begin
            r_state <= ST_OFFER;
            r_valid <= 1'b1;
            r_idx   <= w_pidx;
          end
        ST_OFFER:
          // Offer is frozen until accepted; later arrivals never pre-empt it.
          if (bus.ready) begin
            if (w_any) begin
              r_idx <= w_pidx;
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
            end
          end
      endcase
    end
  end

  assign bus.valid   = r_valid;
  assign bus.idx     = r_idx;
  assign bus.pending = r_pending;
  assign bus.ovf     = r_ovf;
endmodule
